user_data_check: RTL and testbench
==================================

// Module: user_data_check
// PURPOSE
//   Receive-side checker for the 64-bit AXI-Stream user data path; counterpart of the TX user data generator.
//   Consumes frames from the PHY RX user interface.
//   Each frame is checked for: incrementing tdata (beat n carries n, starting at 0); tkeep = 8'hFF; exactly
//   P_FRAME_LEN beats, ending in tlast. Reports per-frame status, saturating counters and a sticky error flag
//   to debug logic (ILA/VIO).
// PARAMETERS
//   P_FRAME_LEN  100  beats per frame; legal range 2..65535
// PORTS
//   i_clk              in   1   user clock; the only clock
//   i_rst              in   1   synchronous, active-high reset
//   i_clr              in   1   synchronous clear of counters and sticky flag
//   s_axi_rx_tdata     in   64  RX beat data
//   s_axi_rx_tkeep     in   8   RX byte enables
//   s_axi_rx_tlast     in   1   RX last beat of frame
//   s_axi_rx_tvalid    in   1   RX beat valid; no tready, so every valid cycle is a beat
//   o_frame_done       out  1   1-cycle pulse: a frame ended (tlast seen)
//   o_frame_ok         out  1   status of the frame in o_frame_done; valid only while o_frame_done = 1
//   o_good_cnt         out  16  frames passing all checks, saturating
//   o_bad_cnt          out  16  frames failing any check, saturating
//   o_beat_err_cnt     out  16  beats with a tdata or tkeep mismatch, saturating
//   o_err_sticky       out  1   set on any error; cleared only by i_rst or i_clr
// BEHAVIOUR
//   Reset: one clock, synchronous, active-high. All outputs 0. State goes to S_IDLE. Reset mid-frame drops
//     the partial frame with no report.
//   State machine:
//     S_IDLE: no frame open. Expected index = 0.
//     S_RECV: frame open. r_idx holds the index of the next beat (16 bits).
//     S_DROP: overlong frame. Beats are discarded until tlast.
//   Beat checks in S_IDLE/S_RECV, with idx = 0 in S_IDLE and r_idx in S_RECV:
//     data_ok = (tdata == {48'd0, idx})
//     keep_ok = (tkeep == 8'hFF)
//     A beat failing either check increments o_beat_err_cnt once (not twice) and marks the frame bad.
//   Transitions on a beat (tvalid = 1):
//     tlast = 1: frame ends and state goes to S_IDLE.
//       The frame is ok only if every beat was ok AND idx == P_FRAME_LEN-1.
//       A short frame (idx < P_FRAME_LEN-1) is reported bad.
//     tlast = 0, idx < P_FRAME_LEN-1: go to or stay in S_RECV; r_idx <= idx + 1.
//     tlast = 0, idx == P_FRAME_LEN-1: overlong frame. Mark it bad and go to S_DROP.
//     S_DROP: beats are not data-checked. On tlast: report the bad frame and go to S_IDLE.
//     A one-beat frame (tlast in S_IDLE) is a short frame: reported bad.
//   No beat (tvalid = 0): state, r_idx and the frame-bad flag all hold. Gaps mid-frame are legal.
//   Reporting latency: o_frame_done/o_frame_ok are registered, asserted the cycle after the tlast beat,
//     for 1 cycle.
//   Counter update latency: counters and sticky flag update in the same edge as o_frame_done. A beat error
//     updates o_beat_err_cnt and o_err_sticky one cycle after its beat.
//   Counters: 16-bit, saturate at 16'hFFFF and never wrap.
//   o_err_sticky is set by any beat error, short frame or overlong frame.
//   Priority: i_rst > i_clr > updates.
//     i_clr zeroes o_good_cnt, o_bad_cnt, o_beat_err_cnt and o_err_sticky. An increment in the same cycle
//       is lost.
//     i_clr does not affect the FSM, o_frame_done or o_frame_ok.
//   Back-to-back frames: tlast on beat k and a new beat 0 on k+1 must be accepted with no idle cycle.
// TESTING
//   1. Three back-to-back frames, tdata 0..99, tkeep FF, tlast on beat 99
//      -> o_frame_done/o_frame_ok = 1 three times, o_good_cnt = 3, bad/beat_err = 0, sticky = 0.
//   2. Frame with beat 37 tdata = 0x55, then frame with beat 10 tkeep = 8'h0F
//      -> o_beat_err_cnt = 2, o_bad_cnt = 2, o_frame_ok = 0 for both, sticky = 1.
//   3. tlast on beat 49 (short), then a good frame
//      -> first reported bad, second ok; o_bad_cnt = 1, o_good_cnt = 1.
//   4. 120-beat frame, tlast on beat 119
//      -> enters S_DROP at beat 99, single o_frame_done after beat 119 with ok = 0.
//      -> o_beat_err_cnt = 0, o_bad_cnt = 1.
//   5. Random tvalid gaps (about 30% idle) inside good frames
//      -> all frames ok; i_rst asserted at beat 50 -> outputs 0, no report.
//      -> Next full frame ok.
//   6. Preload o_bad_cnt near 16'hFFFF, then force bad frames -> count holds at 16'hFFFF.
//      i_clr coincident with o_frame_done -> counters read 0 next cycle.

Source files
------------

// File: rtl/user_data_check.sv
// Receive-side checker for the 64-bit AXI-Stream user data path.
// Verifies incrementing payload, full tkeep and exact frame length, and keeps saturating statistics.
module user_data_check #(
    parameter int P_FRAME_LEN = 100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic [63:0] s_axi_rx_tdata,
    input  logic [7:0]  s_axi_rx_tkeep,
    input  logic        s_axi_rx_tlast,
    input  logic        s_axi_rx_tvalid,
    output logic        o_frame_done,
    output logic        o_frame_ok,
    output logic [15:0] o_good_cnt,
    output logic [15:0] o_bad_cnt,
    output logic [15:0] o_beat_err_cnt,
    output logic        o_err_sticky
);

    localparam logic [15:0] LAST_IDX = 16'(P_FRAME_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

    state_t      state, state_nxt;
    logic [15:0] r_idx, idx_nxt, idx;
    logic        frame_bad, bad_nxt;
    logic        beat_err, done_c, ok_c, at_last;
    logic        frame_done, frame_ok, err_sticky;
    logic [15:0] good_cnt, bad_cnt, beat_err_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A beat seen in S_IDLE is always beat 0 of a fresh frame.
    assign idx     = (state == S_RECV) ? r_idx : 16'd0;
    assign at_last = (idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        idx_nxt   = r_idx;
        bad_nxt   = frame_bad;
        beat_err  = 1'b0;
        done_c    = 1'b0;
        ok_c      = 1'b0;
        if (s_axi_rx_tvalid) begin
            case (state)
                S_IDLE, S_RECV: begin
                    beat_err = (s_axi_rx_tdata != {48'd0, idx}) || (s_axi_rx_tkeep != 8'hFF);
                    bad_nxt  = ((state == S_RECV) && frame_bad) || beat_err;
                    if (s_axi_rx_tlast) begin
                        done_c    = 1'b1;
                        ok_c      = !bad_nxt && at_last;
                        state_nxt = S_IDLE;
                        idx_nxt   = 16'd0;
                        bad_nxt   = 1'b0;
                    end else if (!at_last) begin
                        state_nxt = S_RECV;
                        idx_nxt   = idx + 16'd1;
                    end else begin
                        state_nxt = S_DROP;
                        bad_nxt   = 1'b1;
                    end
                end
                S_DROP: begin
                    if (s_axi_rx_tlast) begin
                        done_c    = 1'b1;
                        state_nxt = S_IDLE;
                        idx_nxt   = 16'd0;
                        bad_nxt   = 1'b0;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            r_idx        <= 16'd0;
            frame_bad    <= 1'b0;
            frame_done   <= 1'b0;
            frame_ok     <= 1'b0;
            good_cnt     <= 16'd0;
            bad_cnt      <= 16'd0;
            beat_err_cnt <= 16'd0;
            err_sticky   <= 1'b0;
        end else begin
            state      <= state_nxt;
            r_idx      <= idx_nxt;
            frame_bad  <= bad_nxt;
            frame_done <= done_c;
            frame_ok   <= ok_c;
            // Clear wins over a same-cycle increment; the FSM and report pulse are unaffected.
            if (i_clr) begin
                good_cnt     <= 16'd0;
                bad_cnt      <= 16'd0;
                beat_err_cnt <= 16'd0;
                err_sticky   <= 1'b0;
            end else begin
                if (done_c && ok_c)
                    good_cnt <= sat_inc(good_cnt);
                if (done_c && !ok_c)
                    bad_cnt <= sat_inc(bad_cnt);
                if (beat_err)
                    beat_err_cnt <= sat_inc(beat_err_cnt);
                if (beat_err || (done_c && !ok_c))
                    err_sticky <= 1'b1;
            end
        end
    end

    assign o_frame_done   = frame_done;
    assign o_frame_ok     = frame_ok;
    assign o_good_cnt     = good_cnt;
    assign o_bad_cnt      = bad_cnt;
    assign o_beat_err_cnt = beat_err_cnt;
    assign o_err_sticky   = err_sticky;

endmodule

// File: tb/tb_user_data_check.sv
// Directed bench for user_data_check: good, corrupted, short, overlong, gapped frames,
// mid-frame reset, counter saturation and clear priority.
module tb_user_data_check;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast, tvalid;
    logic        frame_done, frame_ok, err_sticky;
    logic [15:0] good_cnt, bad_cnt, beat_err_cnt;

    int vectors = 0;
    int errs = 0;
    int done_seen = 0;
    int ok_seen = 0;

    always #5 clk = ~clk;

    user_data_check #(.P_FRAME_LEN(100)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_clr          (clr),
        .s_axi_rx_tdata (tdata),
        .s_axi_rx_tkeep (tkeep),
        .s_axi_rx_tlast (tlast),
        .s_axi_rx_tvalid(tvalid),
        .o_frame_done   (frame_done),
        .o_frame_ok     (frame_ok),
        .o_good_cnt     (good_cnt),
        .o_bad_cnt      (bad_cnt),
        .o_beat_err_cnt (beat_err_cnt),
        .o_err_sticky   (err_sticky)
    );

    // Tally report pulses; outputs are registered so the falling edge is a stable sample point.
    always @(negedge clk) begin
        if (frame_done) begin
            done_seen++;
            if (frame_ok) ok_seen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        @(negedge clk);
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tvalid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tvalid = 1'b0;
            tlast  = 1'b0;
        end
    endtask

    task automatic frame(input int len, input int err_beat, input logic [63:0] err_data,
                         input logic [7:0] err_keep, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && (i % 3 == 1)) idle(1);
            if (i == err_beat) beat(err_data, err_keep, i == len - 1);
            else               beat(64'(i), 8'hFF, i == len - 1);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        tvalid = 1'b0;
        clr    = 1'b1;
        @(negedge clk);
        clr    = 1'b0;
    endtask

    task automatic chk_cnts(input string tag, input int good, input int bad,
                            input int berr, input logic sticky);
        chk({tag, "_good"},   32'(good_cnt),     32'(good));
        chk({tag, "_bad"},    32'(bad_cnt),      32'(bad));
        chk({tag, "_beaterr"}, 32'(beat_err_cnt), 32'(berr));
        chk({tag, "_sticky"}, 32'(err_sticky),   32'(sticky));
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_ok",   32'(frame_ok),   32'd0);
        chk_cnts("rst", 0, 0, 0, 1'b0);

        // Three back-to-back good frames
        frame(100, -1, '0, '0, 1'b0);
        frame(100, -1, '0, '0, 1'b0);
        frame(100, -1, '0, '0, 1'b0);
        idle(3);
        chk("t1_done", 32'(done_seen), 32'd3);
        chk("t1_ok",   32'(ok_seen),   32'd3);
        chk_cnts("t1", 3, 0, 0, 1'b0);

        // Data corruption on beat 37, then tkeep corruption on beat 10
        frame(100, 37, 64'h55, 8'hFF, 1'b0);
        frame(100, 10, 64'd10, 8'h0F, 1'b0);
        idle(3);
        chk("t2_done", 32'(done_seen), 32'd5);
        chk("t2_ok",   32'(ok_seen),   32'd3);
        chk_cnts("t2", 3, 2, 2, 1'b1);

        pulse_clr();
        chk_cnts("clr1", 0, 0, 0, 1'b0);

        // Short frame (tlast on beat 49) then a good one
        frame(50, -1, '0, '0, 1'b0);
        frame(100, -1, '0, '0, 1'b0);
        idle(3);
        chk("t3_done", 32'(done_seen), 32'd7);
        chk("t3_ok",   32'(ok_seen),   32'd4);
        chk_cnts("t3", 1, 1, 0, 1'b1);

        pulse_clr();

        // Overlong 120-beat frame: exactly one bad report after beat 119
        frame(120, -1, '0, '0, 1'b0);
        idle(3);
        chk("t4_done", 32'(done_seen), 32'd8);
        chk("t4_ok",   32'(ok_seen),   32'd4);
        chk_cnts("t4", 0, 1, 0, 1'b1);

        pulse_clr();

        // Gapped good frame, then reset in the middle of a gapped frame
        frame(100, -1, '0, '0, 1'b1);
        idle(3);
        chk("t5_done", 32'(done_seen), 32'd9);
        chk("t5_ok",   32'(ok_seen),   32'd5);
        chk("t5_good", 32'(good_cnt),  32'd1);
        for (int i = 0; i <= 50; i++) begin
            if (i % 3 == 1) idle(1);
            beat(64'(i), 8'hFF, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; tvalid = 1'b0;
        chk("t5r_done", 32'(frame_done), 32'd0);
        chk_cnts("t5r", 0, 0, 0, 1'b0);
        idle(3);
        chk("t5r_nordone", 32'(done_seen), 32'd9);
        frame(100, -1, '0, '0, 1'b0);
        idle(3);
        chk("t5n_done", 32'(done_seen), 32'd10);
        chk("t5n_ok",   32'(ok_seen),   32'd6);
        chk_cnts("t5n", 1, 0, 0, 1'b0);

        // Saturation of the bad-frame counter from a preloaded value
        pulse_clr();
        force dut.bad_cnt = 16'hFFFD;
        @(negedge clk);
        release dut.bad_cnt;
        chk("t6_preload", 32'(bad_cnt), 32'hFFFD);
        beat(64'd0, 8'hFF, 1'b1);
        idle(2);
        chk("t6_fffe", 32'(bad_cnt), 32'hFFFE);
        beat(64'd0, 8'hFF, 1'b1);
        beat(64'd0, 8'hFF, 1'b1);
        idle(2);
        chk("t6_ffff", 32'(bad_cnt), 32'hFFFF);
        beat(64'd0, 8'hFF, 1'b1);
        idle(2);
        chk("t6_hold", 32'(bad_cnt), 32'hFFFF);
        chk("t6_done", 32'(done_seen), 32'd14);
        chk("t6_sticky", 32'(err_sticky), 32'd1);

        // Clear in the same cycle as the update edge: increment lost, report still pulses
        @(negedge clk);
        tdata = '0; tkeep = 8'hFF; tlast = 1'b1; tvalid = 1'b1; clr = 1'b1;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0; clr = 1'b0;
        chk("t6c_pulse", 32'(frame_done), 32'd1);
        chk("t6c_okflag", 32'(frame_ok), 32'd0);
        chk_cnts("t6c", 0, 0, 0, 1'b0);
        idle(2);
        chk("t6c_done", 32'(done_seen), 32'd15);
        chk("t6c_bad2", 32'(bad_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
